alu_block_64: RTL and testbench

ALU_BLOCK_64 -- requirements
Module: alu_block_64

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_add64.sv | 23 ++
 rtl/alu_block_64.sv | 102 ++++++++++
 tb/tb_alu_block_64.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit ALU block: data width, operation codes,
// condition-code record and flag helper functions.
package alu_pkg;

    localparam int unsigned DataWidth = 64;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpXor = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic sign;
        logic ovf;
    } alu_cc_t;

    // Signed overflow judged from operand and result sign bits only.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic is_arith(input alu_op_e op);
        return (op == OpAdd) || (op == OpSub);
    endfunction

endpackage

// File: rtl/alu_add64.sv
// 64-bit ripple-carry adder shared by the add and subtract operations.
module alu_add64
    import alu_pkg::*;
(
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic                 cin,
    output logic [DataWidth-1:0] sum,
    output logic                 cout
);

    logic [DataWidth:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DataWidth; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[DataWidth];

endmodule

// File: rtl/alu_block_64.sv
// 64-bit ALU (add/sub/and/xor) with combinational result and an optional
// condition-code register enabled by the ALU_BLOCK_CC_EN macro.
module alu_block_64
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] Ain,
    input  logic [DataWidth-1:0] Bin,
    input  logic                 S1,
    input  logic                 S0,
    input  logic                 set_cc,
    output logic [DataWidth:0]   Final_Output,
    output logic                 zf,
    output logic                 sf,
    output logic                 of
);

    alu_op_e              op;
    logic [DataWidth-1:0] add_b;
    logic                 add_cin;
    logic [DataWidth-1:0] add_sum;
    logic                 add_cout;
    logic [DataWidth-1:0] result;
    logic                 carry_out;
    alu_cc_t              cc_comb;

    assign op = alu_op_e'({S1, S0});

    // Subtraction reuses the adder as Ain + ~Bin + 1.
    always_comb begin
        add_b   = Bin;
        add_cin = 1'b0;
        if (op == OpSub) begin
            add_b   = ~Bin;
            add_cin = 1'b1;
        end
    end

    alu_add64 u_add64 (
        .a    (Ain),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        result    = add_sum;
        carry_out = 1'b0;
        unique case (op)
            OpAdd, OpSub: begin
                result    = add_sum;
                carry_out = add_cout;
            end
            OpAnd: result = Ain & Bin;
            OpXor: result = Ain ^ Bin;
            default: ;
        endcase
    end

    assign Final_Output = {carry_out, result};

    always_comb begin
        cc_comb.zero = (result == '0);
        cc_comb.sign = result[DataWidth-1];
        cc_comb.ovf  = 1'b0;
        if (is_arith(op)) begin
            cc_comb.ovf = (op == OpAdd)
                ? add_ovf(Ain[DataWidth-1], Bin[DataWidth-1], result[DataWidth-1])
                : sub_ovf(Ain[DataWidth-1], Bin[DataWidth-1], result[DataWidth-1]);
        end
    end

`ifdef ALU_BLOCK_CC_EN
    alu_cc_t cc_q;
    alu_cc_t cc_d;

    assign cc_d = set_cc ? cc_comb : cc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign zf = cc_q.zero;
    assign sf = cc_q.sign;
    assign of = cc_q.ovf;
`else
    // Flag logic is compiled out; inputs and combinational flags are intentionally unused.
    logic unused_cc_inputs;
    assign unused_cc_inputs = ^{clk, rst, set_cc, cc_comb};

    assign zf = 1'b0;
    assign sf = 1'b0;
    assign of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_block_64.sv
// Self-checking bench for alu_block_64: directed vector table, hold/reset
// sequences and randomized checks against a plain-arithmetic reference model.
module tb_alu_block_64;

`ifdef ALU_BLOCK_CC_EN
    localparam bit CcEn = 1'b1;
`else
    localparam bit CcEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] Ain;
    logic [63:0] Bin;
    logic        S1;
    logic        S0;
    logic        set_cc;
    logic [64:0] Final_Output;
    logic        zf;
    logic        sf;
    logic        of;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_cc;  // {zf, sf, of} the bench expects to see registered

    alu_block_64 dut (
        .clk          (clk),
        .rst          (rst),
        .Ain          (Ain),
        .Bin          (Bin),
        .S1           (S1),
        .S0           (S0),
        .set_cc       (set_cc),
        .Final_Output (Final_Output),
        .zf           (zf),
        .sf           (sf),
        .of           (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [64:0] out;
        logic        z;
        logic        s;
        logic        o;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic        cc;
        logic [64:0] out;
        logic        z;
        logic        s;
        logic        o;
    } vec_t;

    // Reference: exact signed arithmetic in 66 bits, overflow when the
    // wrapped 64-bit result no longer equals the exact value.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] op);
        res_t r;
        logic signed [65:0] exact;
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        case (op)
            2'd0: begin
                r.out = {1'b0, a} + {1'b0, b};
                exact = sa + sb;
            end
            2'd1: begin
                r.out = {1'b0, a} + {1'b0, ~b} + 65'd1;
                exact = sa - sb;
            end
            2'd2: begin
                r.out = {1'b0, a & b};
                exact = 66'sd0;
            end
            default: begin
                r.out = {1'b0, a ^ b};
                exact = 66'sd0;
            end
        endcase
        r.z = (r.out[63:0] == 64'd0);
        r.s = r.out[63];
        r.o = (op < 2'd2) && (exact != $signed({{2{r.out[63]}}, r.out[63:0]}));
        return r;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                        input logic cc, input logic [64:0] e_out, input logic ez,
                        input logic es, input logic eo, input string tag);
        @(negedge clk);
        Ain    = a;
        Bin    = b;
        {S1, S0} = op;
        set_cc = cc;
        #1;
        check({tag, " out"}, Final_Output, e_out);
        @(posedge clk);
        if (cc && CcEn) exp_cc = {ez, es, eo};
        #1;
        check({tag, " flags"}, {62'd0, zf, sf, of}, {62'd0, exp_cc});
    endtask

    vec_t vecs[$];
    res_t r;

    initial begin
        vecs.push_back('{64'd5, 64'd3, 2'd0, 1'b1, 65'h0_0000000000000008, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{64'd3, 64'd5, 2'd1, 1'b1, 65'h0_FFFFFFFFFFFFFFFE, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{64'h7FFFFFFFFFFFFFFF, 64'd1, 2'd0, 1'b1, 65'h0_8000000000000000,
                         1'b0, 1'b1, 1'b1});
        vecs.push_back('{64'hF0F0, 64'hFF00, 2'd2, 1'b1, 65'h0_000000000000F000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{64'hF0F0, 64'hFF00, 2'd3, 1'b1, 65'h0_0000000000000FF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{64'h1234, 64'h1234, 2'd3, 1'b1, 65'h0_0000000000000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{64'd5, 64'd5, 2'd1, 1'b1, 65'h1_0000000000000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{64'h8000000000000000, 64'd1, 2'd1, 1'b1, 65'h1_7FFFFFFFFFFFFFFF,
                         1'b0, 1'b0, 1'b1});
        vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 64'd1, 2'd0, 1'b1, 65'h1_0000000000000000,
                         1'b1, 1'b0, 1'b0});
        vecs.push_back('{64'h8000000000000000, 64'h8000000000000000, 2'd0, 1'b1,
                         65'h1_0000000000000000, 1'b1, 1'b0, 1'b1});

        Ain = '0;
        Bin = '0;
        {S1, S0} = 2'b00;
        set_cc = 1'b0;
        rst = 1'b0;
        exp_cc = 3'b000;
        #1 rst = 1'b1;
        #1;
        check("reset flags", {62'd0, zf, sf, of}, 65'd0);
        check("reset out", Final_Output, 65'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cc, vecs[i].out,
                 vecs[i].z, vecs[i].s, vecs[i].o, $sformatf("vec%0d", i));
        end

        // Hold: flags must not move while set_cc is low.
        step(64'd3, 64'd5, 2'd1, 1'b1, 65'h0_FFFFFFFFFFFFFFFE, 1'b0, 1'b1, 1'b0, "hold load");
        for (int i = 0; i < 4; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            logic [1:0]  op;
            a  = (i == 0) ? 64'd7 : {$urandom, $urandom};
            b  = (i == 0) ? 64'd7 : {$urandom, $urandom};
            op = (i == 0) ? 2'd1 : 2'($urandom_range(0, 3));
            r = model(a, b, op);
            step(a, b, op, 1'b0, r.out, r.z, r.s, r.o, $sformatf("hold%0d", i));
        end

        // Reset mid-cycle with flags set; output keeps tracking operands.
        step(64'h7FFFFFFFFFFFFFFF, 64'd1, 2'd0, 1'b1, 65'h0_8000000000000000, 1'b0, 1'b1, 1'b1,
             "pre-reset");
        @(negedge clk);
        Ain = 64'd10;
        Bin = 64'd4;
        {S1, S0} = 2'b01;
        set_cc = 1'b1;
        #2 rst = 1'b1;
        exp_cc = 3'b000;
        #1;
        check("midcycle reset flags", {62'd0, zf, sf, of}, 65'd0);
        check("out during reset", Final_Output, 65'h1_0000000000000006);
        Ain = 64'd1;
        Bin = 64'd2;
        #1;
        check("out tracks in reset", Final_Output, 65'h0_FFFFFFFFFFFFFFFF);
        @(posedge clk);
        #1;
        check("reset beats set_cc", {62'd0, zf, sf, of}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        set_cc = 1'b0;

        // Randomized with corner biasing.
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            logic [1:0]  op;
            logic        cc;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 64'h7FFFFFFFFFFFFFFF;
                2: a = 64'h8000000000000000;
                3: b = 64'hFFFFFFFFFFFFFFFF;
                default: ;
            endcase
            op = 2'($urandom_range(0, 3));
            cc = 1'($urandom_range(0, 1));
            r = model(a, b, op);
            step(a, b, op, cc, r.out, r.z, r.s, r.o, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
